inv_factorial: RTL and testbench

Inverse of the iterative factorial unit. Given an operand N, it finds the largest x such that x! <= N. It also reports whether N equals x! exactly. The block is sequential: a controller FSM steers a small register/multiplier/comparator datapath, one multiply per cycle. It sits beside the factorial unit and checks results in the opposite direction, e.g. recovering X from a factorial value.

---
 rtl/inv_factorial_pkg.sv | 13 +
 rtl/inv_factorial_datapath.sv | 64 ++++++
 rtl/inv_factorial.sv | 119 +++++++++++
 tb/tb_inv_factorial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/inv_factorial_pkg.sv
// Shared definitions for the inverse-factorial unit: controller state
// encoding and the load value used to seed the running factorial and index.
package inv_factorial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ONE = 1;

endpackage

// File: rtl/inv_factorial_datapath.sv
// Datapath for the inverse-factorial unit: operand, running-factorial and
// index registers, the incrementer, the double-width multiplier and compares.
module inv_factorial_datapath
  import inv_factorial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] n_in,
  input  logic             n_load,
  input  logic             fi_load,
  input  logic             sel_one,
  output logic [WIDTH-1:0] i_val,
  output logic             le_n,
  output logic             n_zero,
  output logic             f_eq_n
);

  logic [WIDTH-1:0]   n_reg;
  logic [WIDTH-1:0]   f_reg;
  logic [WIDTH-1:0]   i_reg;
  logic [WIDTH-1:0]   i_inc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   f_next;
  logic [WIDTH-1:0]   i_next;

  // The product is formed at double width so the compare against n_reg can
  // never be fooled by a wrapped factorial, even for an all-ones operand.
  assign i_inc  = i_reg + {{(WIDTH-1){1'b0}}, 1'b1};
  assign prod   = {{WIDTH{1'b0}}, f_reg} * {{WIDTH{1'b0}}, i_inc};
  assign le_n   = (prod <= {{WIDTH{1'b0}}, n_reg});
  assign n_zero = (n_reg == {WIDTH{1'b0}});
  assign f_eq_n = (f_reg == n_reg);
  assign f_next = sel_one ? WIDTH'(ONE) : prod[WIDTH-1:0];
  assign i_next = sel_one ? WIDTH'(ONE) : i_inc;
  assign i_val  = i_reg;

  // Operand register, loaded only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg <= {WIDTH{1'b0}};
    end else if (n_load) begin
      n_reg <= n_in;
    end else begin
      n_reg <= n_reg;
    end
  end

  // Running factorial and index registers, seeded to one or stepped forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_reg <= {WIDTH{1'b0}};
      i_reg <= {WIDTH{1'b0}};
    end else if (fi_load) begin
      f_reg <= f_next;
      i_reg <= i_next;
    end else begin
      f_reg <= f_reg;
      i_reg <= i_reg;
    end
  end

endmodule

// File: rtl/inv_factorial.sv
// Inverse factorial: finds the largest x with x! <= N, one multiply per cycle,
// and flags whether N is exactly x!. Holds the controller FSM and result regs.
module inv_factorial
  import inv_factorial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int XW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] N,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [XW-1:0]    x_out,
  output logic             exact
);

  state_t           state;
  state_t           state_next;
  logic             n_load;
  logic             fi_load;
  logic             sel_one;
  logic             res_load;
  logic             res_zero;
  logic [WIDTH-1:0] i_val;
  logic             le_n;
  logic             n_zero;
  logic             f_eq_n;

  inv_factorial_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (CLK),
    .rst_n  (RST),
    .n_in   (N),
    .n_load (n_load),
    .fi_load(fi_load),
    .sel_one(sel_one),
    .i_val  (i_val),
    .le_n   (le_n),
    .n_zero (n_zero),
    .f_eq_n (f_eq_n)
  );

  // Controller state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    n_load     = 1'b0;
    fi_load    = 1'b0;
    sel_one    = 1'b0;
    res_load   = 1'b0;
    res_zero   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          n_load     = 1'b1;
          fi_load    = 1'b1;
          sel_one    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (n_zero) begin
          res_load   = 1'b1;
          res_zero   = 1'b1;
          state_next = DONE;
        end else if (le_n) begin
          fi_load    = 1'b1;
          state_next = RUN;
        end else begin
          res_load   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags registered from the upcoming state so they align with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

  // Result registers only move on the transition into DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x_out <= {XW{1'b0}};
      exact <= 1'b0;
    end else if (res_load) begin
      x_out <= res_zero ? {XW{1'b0}} : XW'(i_val);
      exact <= res_zero ? 1'b0 : f_eq_n;
    end else begin
      x_out <= x_out;
      exact <= exact;
    end
  end

endmodule

// File: tb/tb_inv_factorial.sv
// Self-checking bench for inv_factorial: directed table, protocol corners,
// random operands against a factorial-table reference, and mid-run reset.
module tb_inv_factorial;

  logic       CLK;
  logic       RST;
  logic [7:0] N;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic       exact;

  int checks = 0;
  int errors = 0;

  inv_factorial #(.WIDTH(8), .XW(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .N    (N),
    .start(start),
    .busy (busy),
    .done (done),
    .x_out(x_out),
    .exact(exact)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] n;
    int         x;
    int         ex;
    int         lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int fact(input int k);
    int f = 1;
    for (int j = 2; j <= k; j++) f = f * j;
    return f;
  endfunction

  function automatic int ref_x(input int n);
    int best = 0;
    for (int x = 0; x <= 10; x++) if (fact(x) <= n) best = x;
    return best;
  endfunction

  function automatic int ref_exact(input int n);
    return (n != 0 && fact(ref_x(n)) == n) ? 1 : 0;
  endfunction

  // Issue one operation; optionally pulse start with another operand at cycle intr_cyc.
  task automatic run_op(input logic [7:0] n, input int intr_cyc, input logic [7:0] intr_n,
                        input int exp_x, input int exp_ex, input int exp_lat, input string tag);
    logic [7:0] hold_x;
    logic       hold_e;
    bit         seen;
    hold_x = x_out;
    hold_e = exact;
    seen   = 1'b0;
    N      = n;
    start  = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge CLK);
      if (c == intr_cyc) begin
        start = 1'b1;
        N     = intr_n;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, " latency"}, c, exp_lat);
        chk({tag, " x_out"}, int'(x_out), exp_x);
        chk({tag, " exact"}, int'(exact), exp_ex);
        chk({tag, " busy_in_done"}, int'(busy), 1);
      end else begin
        chk({tag, " busy_run"}, int'(busy), 1);
        chk({tag, " x_hold"}, int'(x_out), int'(hold_x));
        chk({tag, " exact_hold"}, int'(exact), int'(hold_e));
      end
    end
    start = 1'b0;
    if (!seen) chk({tag, " done_timeout"}, 0, 1);
    @(negedge CLK);
    chk({tag, " done_width"}, int'(done), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int rx;

    tbl[0] = '{8'd120, 5, 1, 6};
    tbl[1] = '{8'd6,   3, 1, 4};
    tbl[2] = '{8'd2,   2, 1, 3};
    tbl[3] = '{8'd5,   2, 0, 3};
    tbl[4] = '{8'd255, 5, 0, 6};
    tbl[5] = '{8'd23,  3, 0, 4};
    tbl[6] = '{8'd0,   0, 0, 2};
    tbl[7] = '{8'd1,   1, 1, 2};
    tbl[8] = '{8'd24,  4, 1, 5};

    // Reset held with start asserted must not launch anything.
    RST   = 1'b0;
    start = 1'b1;
    N     = 8'd120;
    repeat (3) @(negedge CLK);
    chk("reset busy", int'(busy), 0);
    RST   = 1'b1;
    start = 1'b0;
    @(negedge CLK);
    chk("reset busy_after", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset x_out", int'(x_out), 0);
    chk("reset exact", int'(exact), 0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].n, 0, 8'd0, tbl[i].x, tbl[i].ex, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // Start and operand change while running must be ignored.
    run_op(8'd24, 2, 8'd2, 4, 1, 5, "intrude");
    // Back-to-back restart right after done.
    run_op(8'd6, 0, 8'd0, 3, 1, 4, "restart");

    for (int i = 0; i < 30; i++) begin
      n  = int'($urandom_range(0, 255));
      rx = ref_x(n);
      run_op(8'(n), 0, 8'd0, rx, ref_exact(n), (rx == 0) ? 2 : rx + 1,
             $sformatf("rand%0d_n%0d", i, n));
    end

    // Mid-operation reset clears outputs at once and suppresses done.
    run_op(8'd24, 0, 8'd0, 4, 1, 5, "pre_reset");
    N     = 8'd120;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst x_out", int'(x_out), 0);
    chk("midrst exact", int'(exact), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("midrst no_done", int'(done), 0);
      chk("midrst idle", int'(busy), 0);
    end
    run_op(8'd6, 0, 8'd0, 3, 1, 4, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
